// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage and its neighbours (mem, commit ctrl).
// Holds lane/width constants, exception-source slot indices and the per-lane
// commit record so every stage agrees on field packing.
package wb_stage_pkg;

  localparam int unsigned LANES    = 2;
  localparam int unsigned CAUSE_W  = 7;
  localparam int unsigned NSRC     = 6;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned CSR_AW   = 14;
  localparam int unsigned EXCP_W   = NSRC;
  localparam int unsigned CAUSE_LW = NSRC * CAUSE_W;

  // Exception-source slot indices within a lane's excp/cause fields.
  localparam int unsigned SRC_COMMIT   = 0;
  localparam int unsigned SRC_EXECUTE  = 1;
  localparam int unsigned SRC_DISPATCH = 2;
  localparam int unsigned SRC_DECODER  = 3;
  localparam int unsigned SRC_INSTBUF  = 4;
  localparam int unsigned SRC_PC       = 5;

  // One lane's commit record as carried from mem to the commit controller.
  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     addr;
    logic                reg_we;
    logic [REG_AW-1:0]   reg_waddr;
    logic [XLEN-1:0]     reg_wdata;
    logic                csr_we;
    logic [CSR_AW-1:0]   csr_waddr;
    logic [XLEN-1:0]     csr_wdata;
    logic                llsc;
    logic                idle;
    logic                ertn;
    logic                priv;
    logic [EXCP_W-1:0]   excp;
    logic [CAUSE_LW-1:0] cause;
  } wb_lane_t;

  localparam int unsigned LANE_W = $bits(wb_lane_t);

  // Zero every field that can cause an architectural effect; data is left stale.
  function automatic wb_lane_t clear_side(input wb_lane_t r);
    wb_lane_t c;
    c        = r;
    c.valid  = 1'b0;
    c.reg_we = 1'b0;
    c.csr_we = 1'b0;
    c.llsc   = 1'b0;
    c.idle   = 1'b0;
    c.ertn   = 1'b0;
    c.priv   = 1'b0;
    c.excp   = '0;
    return c;
  endfunction

endpackage

// File: rtl/wb_lane_reg.sv
// One lane's writeback register slice.
// Ports: clk, rst (sync, active-low), clear (zero sideband), hold (keep),
//        load (capture d), d (mem record), q (registered record).
// Priority: reset > clear > hold > load. Invalid lanes are stored with their
// sideband already zeroed so consumers need not re-check valid.
module wb_lane_reg
  import wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              hold,
  input  logic              load,
  input  logic [LANE_W-1:0] d,
  output logic [LANE_W-1:0] q
);

  wb_lane_t d_s;
  wb_lane_t q_r;

  assign d_s = wb_lane_t'(d);
  assign q   = q_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r <= '0;
    end else if (clear) begin
      q_r <= clear_side(q_r);
    end else if (!hold && load) begin
      q_r <= d_s.valid ? d_s : clear_side(d_s);
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Dual-lane writeback pipeline register between mem and the commit controller.
// Inputs : clk, rst (sync active-low), flush_wb, pause_wb, pause_mem, mem_*_i
//          per-lane fields packed {lane1, lane0}.
// Outputs: wb_*_o registered copies of mem_*_i, wb_any_valid_o = |wb_valid_o.
// Optional: define WB_STAGE_DIFFTEST_EN to add wb_commit_cnt_o, wb_commit_pc_o,
//           wb_commit_v_o (committed-instruction count and delayed commit trace).
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_wb,
  input  logic                        pause_wb,
  input  logic                        pause_mem,
  input  logic [LANES-1:0]            mem_valid_i,
  input  logic [LANES*XLEN-1:0]       mem_pc_i,
  input  logic [LANES*XLEN-1:0]       mem_addr_i,
  input  logic [LANES-1:0]            mem_reg_we_i,
  input  logic [LANES*REG_AW-1:0]     mem_reg_waddr_i,
  input  logic [LANES*XLEN-1:0]       mem_reg_wdata_i,
  input  logic [LANES-1:0]            mem_csr_we_i,
  input  logic [LANES*CSR_AW-1:0]     mem_csr_waddr_i,
  input  logic [LANES*XLEN-1:0]       mem_csr_wdata_i,
  input  logic [LANES-1:0]            mem_llsc_i,
  input  logic [LANES-1:0]            mem_idle_i,
  input  logic [LANES-1:0]            mem_ertn_i,
  input  logic [LANES-1:0]            mem_priv_i,
  input  logic [LANES*EXCP_W-1:0]     mem_excp_i,
  input  logic [LANES*CAUSE_LW-1:0]   mem_cause_i,
  output logic [LANES-1:0]            wb_valid_o,
  output logic [LANES*XLEN-1:0]       wb_pc_o,
  output logic [LANES*XLEN-1:0]       wb_addr_o,
  output logic [LANES-1:0]            wb_reg_we_o,
  output logic [LANES*REG_AW-1:0]     wb_reg_waddr_o,
  output logic [LANES*XLEN-1:0]       wb_reg_wdata_o,
  output logic [LANES-1:0]            wb_csr_we_o,
  output logic [LANES*CSR_AW-1:0]     wb_csr_waddr_o,
  output logic [LANES*XLEN-1:0]       wb_csr_wdata_o,
  output logic [LANES-1:0]            wb_llsc_o,
  output logic [LANES-1:0]            wb_idle_o,
  output logic [LANES-1:0]            wb_ertn_o,
  output logic [LANES-1:0]            wb_priv_o,
  output logic [LANES*EXCP_W-1:0]     wb_excp_o,
  output logic [LANES*CAUSE_LW-1:0]   wb_cause_o,
  output logic                        wb_any_valid_o
`ifdef WB_STAGE_DIFFTEST_EN
  ,
  output logic [31:0]                 wb_commit_cnt_o,
  output logic [LANES*XLEN-1:0]       wb_commit_pc_o,
  output logic [LANES-1:0]            wb_commit_v_o
`endif
);

  // A stalled mem must not be captured twice, so it inserts a bubble like a flush.
  logic clear_c;
  logic hold_c;
  logic load_c;

  assign clear_c = flush_wb | (pause_mem & ~pause_wb);
  assign hold_c  = pause_wb;
  assign load_c  = ~pause_mem;

  wb_lane_t lane_d [LANES];
  wb_lane_t lane_q [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_d[i] = '{
      valid:     mem_valid_i[i],
      pc:        mem_pc_i[i*XLEN +: XLEN],
      addr:      mem_addr_i[i*XLEN +: XLEN],
      reg_we:    mem_reg_we_i[i],
      reg_waddr: mem_reg_waddr_i[i*REG_AW +: REG_AW],
      reg_wdata: mem_reg_wdata_i[i*XLEN +: XLEN],
      csr_we:    mem_csr_we_i[i],
      csr_waddr: mem_csr_waddr_i[i*CSR_AW +: CSR_AW],
      csr_wdata: mem_csr_wdata_i[i*XLEN +: XLEN],
      llsc:      mem_llsc_i[i],
      idle:      mem_idle_i[i],
      ertn:      mem_ertn_i[i],
      priv:      mem_priv_i[i],
      excp:      mem_excp_i[i*EXCP_W +: EXCP_W],
      cause:     mem_cause_i[i*CAUSE_LW +: CAUSE_LW]
    };

    wb_lane_reg u_lane (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_c),
      .hold  (hold_c),
      .load  (load_c),
      .d     (lane_d[i]),
      .q     (lane_q[i])
    );

    assign wb_valid_o[i]                          = lane_q[i].valid;
    assign wb_pc_o[i*XLEN +: XLEN]                = lane_q[i].pc;
    assign wb_addr_o[i*XLEN +: XLEN]              = lane_q[i].addr;
    assign wb_reg_we_o[i]                         = lane_q[i].reg_we;
    assign wb_reg_waddr_o[i*REG_AW +: REG_AW]     = lane_q[i].reg_waddr;
    assign wb_reg_wdata_o[i*XLEN +: XLEN]         = lane_q[i].reg_wdata;
    assign wb_csr_we_o[i]                         = lane_q[i].csr_we;
    assign wb_csr_waddr_o[i*CSR_AW +: CSR_AW]     = lane_q[i].csr_waddr;
    assign wb_csr_wdata_o[i*XLEN +: XLEN]         = lane_q[i].csr_wdata;
    assign wb_llsc_o[i]                           = lane_q[i].llsc;
    assign wb_idle_o[i]                           = lane_q[i].idle;
    assign wb_ertn_o[i]                           = lane_q[i].ertn;
    assign wb_priv_o[i]                           = lane_q[i].priv;
    assign wb_excp_o[i*EXCP_W +: EXCP_W]          = lane_q[i].excp;
    assign wb_cause_o[i*CAUSE_LW +: CAUSE_LW]     = lane_q[i].cause;
  end

  assign wb_any_valid_o = |wb_valid_o;

`ifdef WB_STAGE_DIFFTEST_EN
  // Lanes presented this cycle that actually retire: valid, not held, no exception.
  logic [LANES-1:0] commit_c;
  logic [1:0]       commit_n_c;

  for (genvar i = 0; i < LANES; i++) begin : g_commit
    assign commit_c[i] = lane_q[i].valid & ~pause_wb & ~(|lane_q[i].excp);
  end

  assign commit_n_c = {1'b0, commit_c[0]} + {1'b0, commit_c[1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_commit_cnt_o <= '0;
      wb_commit_pc_o  <= '0;
      wb_commit_v_o   <= '0;
    end else begin
      wb_commit_cnt_o <= wb_commit_cnt_o + 32'(commit_n_c);
      wb_commit_pc_o  <= wb_pc_o;
      wb_commit_v_o   <= commit_c;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// pause/flush/reset traffic, with a queue of expected wb outputs.
module tb_wb_stage;

  typedef struct packed {
    logic [1:0]  valid;
    logic [63:0] pc;
    logic [63:0] addr;
    logic [1:0]  reg_we;
    logic [9:0]  reg_waddr;
    logic [63:0] reg_wdata;
    logic [1:0]  csr_we;
    logic [27:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic [1:0]  llsc;
    logic [1:0]  idle;
    logic [1:0]  ertn;
    logic [1:0]  priv;
    logic [11:0] excp;
    logic [83:0] cause;
  } io_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush_wb = 1'b0;
  logic pause_wb = 1'b0;
  logic pause_mem = 1'b0;

  io_t mi = '0;
  io_t cur = '0;
  io_t e;
  io_t act;
  io_t exp_q[$];

  logic [1:0]  wb_valid_o, wb_reg_we_o, wb_csr_we_o;
  logic [1:0]  wb_llsc_o, wb_idle_o, wb_ertn_o, wb_priv_o;
  logic [63:0] wb_pc_o, wb_addr_o, wb_reg_wdata_o, wb_csr_wdata_o;
  logic [9:0]  wb_reg_waddr_o;
  logic [27:0] wb_csr_waddr_o;
  logic [11:0] wb_excp_o;
  logic [83:0] wb_cause_o;
  logic        wb_any_valid_o;
`ifdef WB_STAGE_DIFFTEST_EN
  logic [31:0] wb_commit_cnt_o;
  logic [63:0] wb_commit_pc_o;
  logic [1:0]  wb_commit_v_o;
  logic [31:0] e_cnt = '0;
  logic [63:0] e_cpc = '0;
  logic [1:0]  e_cv = '0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush_wb        (flush_wb),
    .pause_wb        (pause_wb),
    .pause_mem       (pause_mem),
    .mem_valid_i     (mi.valid),
    .mem_pc_i        (mi.pc),
    .mem_addr_i      (mi.addr),
    .mem_reg_we_i    (mi.reg_we),
    .mem_reg_waddr_i (mi.reg_waddr),
    .mem_reg_wdata_i (mi.reg_wdata),
    .mem_csr_we_i    (mi.csr_we),
    .mem_csr_waddr_i (mi.csr_waddr),
    .mem_csr_wdata_i (mi.csr_wdata),
    .mem_llsc_i      (mi.llsc),
    .mem_idle_i      (mi.idle),
    .mem_ertn_i      (mi.ertn),
    .mem_priv_i      (mi.priv),
    .mem_excp_i      (mi.excp),
    .mem_cause_i     (mi.cause),
    .wb_valid_o      (wb_valid_o),
    .wb_pc_o         (wb_pc_o),
    .wb_addr_o       (wb_addr_o),
    .wb_reg_we_o     (wb_reg_we_o),
    .wb_reg_waddr_o  (wb_reg_waddr_o),
    .wb_reg_wdata_o  (wb_reg_wdata_o),
    .wb_csr_we_o     (wb_csr_we_o),
    .wb_csr_waddr_o  (wb_csr_waddr_o),
    .wb_csr_wdata_o  (wb_csr_wdata_o),
    .wb_llsc_o       (wb_llsc_o),
    .wb_idle_o       (wb_idle_o),
    .wb_ertn_o       (wb_ertn_o),
    .wb_priv_o       (wb_priv_o),
    .wb_excp_o       (wb_excp_o),
    .wb_cause_o      (wb_cause_o),
    .wb_any_valid_o  (wb_any_valid_o)
`ifdef WB_STAGE_DIFFTEST_EN
    ,
    .wb_commit_cnt_o (wb_commit_cnt_o),
    .wb_commit_pc_o  (wb_commit_pc_o),
    .wb_commit_v_o   (wb_commit_v_o)
`endif
  );

  assign act = '{valid: wb_valid_o, pc: wb_pc_o, addr: wb_addr_o,
                 reg_we: wb_reg_we_o, reg_waddr: wb_reg_waddr_o,
                 reg_wdata: wb_reg_wdata_o, csr_we: wb_csr_we_o,
                 csr_waddr: wb_csr_waddr_o, csr_wdata: wb_csr_wdata_o,
                 llsc: wb_llsc_o, idle: wb_idle_o, ertn: wb_ertn_o,
                 priv: wb_priv_o, excp: wb_excp_o, cause: wb_cause_o};

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic io_t side0(input io_t x);
    io_t c = x;
    c.valid = '0; c.reg_we = '0; c.csr_we = '0; c.llsc = '0;
    c.idle = '0; c.ertn = '0; c.priv = '0; c.excp = '0;
    return c;
  endfunction

  // Reference next-state of the wb outputs.
  function automatic io_t model(input io_t p, input io_t m, input logic r,
                                input logic fl, input logic pw, input logic pm);
    io_t n;
    if (!r) return '0;
    if (fl || (pm && !pw)) return side0(p);
    if (pw) return p;
    n = m;
    for (int i = 0; i < 2; i++) begin
      if (!m.valid[i]) begin
        n.reg_we[i] = 1'b0; n.csr_we[i] = 1'b0; n.llsc[i] = 1'b0;
        n.idle[i] = 1'b0; n.ertn[i] = 1'b0; n.priv[i] = 1'b0;
        n.excp[i*6 +: 6] = 6'h0;
      end
    end
    return n;
  endfunction

  task automatic rand_mi();
    mi.valid     = 2'($urandom);
    mi.pc        = {$urandom, $urandom};
    mi.addr      = {$urandom, $urandom};
    mi.reg_we    = 2'($urandom);
    mi.reg_waddr = 10'($urandom);
    mi.reg_wdata = {$urandom, $urandom};
    mi.csr_we    = 2'($urandom);
    mi.csr_waddr = 28'($urandom);
    mi.csr_wdata = {$urandom, $urandom};
    mi.llsc      = 2'($urandom);
    mi.idle      = 2'($urandom);
    mi.ertn      = 2'($urandom);
    mi.priv      = 2'($urandom);
    mi.excp      = ($urandom_range(0, 1) == 0) ? 12'h0 : 12'($urandom);
    mi.cause     = 84'({$urandom, $urandom, $urandom});
  endtask

  // Drive one cycle (called just after a negedge), push the expectation,
  // then compare on the following posedge + 1.
  task automatic cycle(input logic r, input logic fl, input logic pw, input logic pm);
    rst = r; flush_wb = fl; pause_wb = pw; pause_mem = pm;
    exp_q.push_back(model(cur, mi, r, fl, pw, pm));
`ifdef WB_STAGE_DIFFTEST_EN
    begin
      logic [1:0] cv;
      for (int i = 0; i < 2; i++)
        cv[i] = cur.valid[i] & ~pw & (cur.excp[i*6 +: 6] == 6'h0);
      if (!r) begin
        e_cnt = '0; e_cv = '0; e_cpc = '0;
      end else begin
        e_cnt = e_cnt + 32'(cv[0]) + 32'(cv[1]);
        e_cv  = cv;
        e_cpc = cur.pc;
      end
    end
`endif
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    cur = e;
    chk("valid", 512'(act.valid), 512'(e.valid));
    chk("reg_we", 512'(act.reg_we), 512'(e.reg_we));
    chk("csr_we", 512'(act.csr_we), 512'(e.csr_we));
    chk("side", 512'({act.llsc, act.idle, act.ertn, act.priv, act.excp}),
                512'({e.llsc, e.idle, e.ertn, e.priv, e.excp}));
    chk("data", 512'({act.pc, act.addr, act.reg_waddr, act.reg_wdata}),
                512'({e.pc, e.addr, e.reg_waddr, e.reg_wdata}));
    chk("csr", 512'({act.csr_waddr, act.csr_wdata}), 512'({e.csr_waddr, e.csr_wdata}));
    chk("cause", 512'(act.cause), 512'(e.cause));
    chk("any_valid", 512'(wb_any_valid_o), 512'(|e.valid));
`ifdef WB_STAGE_DIFFTEST_EN
    chk("commit_cnt", 512'(wb_commit_cnt_o), 512'(e_cnt));
    chk("commit_v", 512'(wb_commit_v_o), 512'(e_cv));
    chk("commit_pc", 512'(wb_commit_pc_o), 512'(e_cpc));
`endif
    @(negedge clk);
  endtask

  initial begin
    io_t snap;
    logic [31:0] l1_pc, l1_wdata;
    @(negedge clk);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("reset_all", 512'(act), 512'(0));

    // Basic load of lane0.
    mi = '0;
    mi.valid = 2'b01;
    mi.pc[31:0] = 32'h1c00_0000;
    mi.reg_we = 2'b01;
    mi.reg_waddr[4:0] = 5'd5;
    mi.reg_wdata[31:0] = 32'hdead_beef;
    cycle(1, 0, 0, 0);
    chk("t1_valid", 512'(wb_valid_o), 512'(2'b01));
    chk("t1_waddr", 512'(wb_reg_waddr_o[4:0]), 512'(5'd5));
    chk("t1_wdata", 512'(wb_reg_wdata_o[31:0]), 512'(32'hdead_beef));
    chk("t1_pc", 512'(wb_pc_o[31:0]), 512'(32'h1c00_0000));

    // Hold for three cycles while mem changes, then flush overriding pause.
    rand_mi(); mi.valid = 2'b11; mi.reg_we = 2'b11; mi.excp = '0;
    cycle(1, 0, 0, 0);
    snap = act;
    for (int k = 0; k < 3; k++) begin
      rand_mi();
      cycle(1, 0, 1, 0);
      chk("t2_frozen", 512'(act), 512'(snap));
    end
    rand_mi(); mi.valid = 2'b11; mi.reg_we = 2'b11;
    cycle(1, 1, 1, 0);
    chk("t2_flush_valid", 512'(wb_valid_o), 512'(2'b00));
    chk("t2_flush_we", 512'(wb_reg_we_o), 512'(2'b00));

    // Bubble while mem is stalled; instruction appears exactly once afterwards.
    rand_mi(); mi.valid = 2'b11; mi.csr_we = 2'b11;
    cycle(1, 0, 0, 1);
    chk("t3_bubble_valid", 512'(wb_valid_o), 512'(2'b00));
    chk("t3_bubble_csr", 512'(wb_csr_we_o), 512'(2'b00));
    cycle(1, 0, 0, 1);
    chk("t3_bubble2_valid", 512'(wb_valid_o), 512'(2'b00));
    cycle(1, 0, 0, 0);
    chk("t3_once_valid", 512'(wb_valid_o), 512'(2'b11));
    chk("t3_once_csr", 512'(wb_csr_we_o), 512'(2'b11));
    mi.valid = 2'b00;
    cycle(1, 0, 0, 0);
    chk("t3_after_valid", 512'(wb_valid_o), 512'(2'b00));

    // Invalid lane0 has its sideband zeroed; lane1 passes through.
    rand_mi();
    mi.valid = 2'b10; mi.reg_we = 2'b11; mi.excp = 12'hfff;
    l1_pc = mi.pc[63:32]; l1_wdata = mi.reg_wdata[63:32];
    cycle(1, 0, 0, 0);
    chk("t4_we0", 512'(wb_reg_we_o[0]), 512'(1'b0));
    chk("t4_excp0", 512'(wb_excp_o[5:0]), 512'(6'h0));
    chk("t4_we1", 512'(wb_reg_we_o[1]), 512'(1'b1));
    chk("t4_excp1", 512'(wb_excp_o[11:6]), 512'(6'h3f));
    chk("t4_pc1", 512'(wb_pc_o[63:32]), 512'(l1_pc));
    chk("t4_wdata1", 512'(wb_reg_wdata_o[63:32]), 512'(l1_wdata));

    // Reset in the middle of back-to-back loads.
    rand_mi(); mi.valid = 2'b11;
    cycle(1, 0, 0, 0);
    rand_mi(); mi.valid = 2'b11;
    cycle(0, 1, 1, 0);
    chk("t5_reset_all", 512'(act), 512'(0));
    rand_mi(); mi.valid = 2'b01;
    snap = mi;
    cycle(1, 0, 0, 0);
    chk("t5_first_valid", 512'(wb_valid_o), 512'(2'b01));
    chk("t5_first_pc", 512'(wb_pc_o), 512'(snap.pc));

`ifdef WB_STAGE_DIFFTEST_EN
    // Commit counter: 10 dual-valid commits, then one partial commit.
    mi = '0;
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      rand_mi(); mi.valid = 2'b11; mi.excp = '0;
      cycle(1, 0, 0, 0);
    end
    mi.valid = 2'b00;
    cycle(1, 0, 0, 0);
    chk("t6_cnt20", 512'(wb_commit_cnt_o), 512'(32'd20));
    rand_mi(); mi.valid = 2'b11; mi.excp = 12'h040;
    cycle(1, 0, 0, 0);
    mi.valid = 2'b00;
    cycle(1, 0, 0, 0);
    chk("t6_cnt21", 512'(wb_commit_cnt_o), 512'(32'd21));
    chk("t6_cv", 512'(wb_commit_v_o), 512'(2'b01));
`endif

    // Randomized pause/flush/reset traffic.
    for (int k = 0; k < 400; k++) begin
      rand_mi();
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
